complex_2n_to_n_serializer: RTL and testbench

COMPLEX_2N_TO_N_SERIALIZER -- requirements
Module: complex_2n_to_n_serializer

---
 rtl/complex_2n_to_n_serializer_pkg.sv | 13 +
 rtl/complex_2n_to_n_serializer_if.sv | 13 +
 rtl/complex_2n_to_n_serializer.sv | 84 ++++++++
 tb/tb_complex_2n_to_n_serializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/complex_2n_to_n_serializer_pkg.sv
// Shared constants and FSM encoding for the complex serializer / N-to-2N demux pair.
package complex_pkg;

    localparam int unsigned NI            = 8;
    localparam int unsigned ELEMENT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } ser_state_e;

endpackage : complex_pkg

// File: rtl/complex_2n_to_n_serializer_if.sv
// Half-vector beat stream between the serializer and the N-to-2N demux.
interface complex_2n_to_n_serializer_if #(
    parameter int unsigned HALF_W = 256
);
    logic [HALF_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              sel;
    logic              last;

    modport master (output data, output valid, output sel, output last, input ready);
    modport slave  (input data, input valid, input sel, input last, output ready);
endinterface : complex_2n_to_n_serializer_if

// File: rtl/complex_2n_to_n_serializer.sv
// Splits a 2*HALF_W vector into a low beat then a high beat, with back-to-back
// capture in HIGH so a stream of vectors sustains one beat per cycle.
module complex_2n_to_n_serializer #(
    parameter  int unsigned NI            = complex_pkg::NI,
    parameter  int unsigned element_width = complex_pkg::ELEMENT_WIDTH,
    localparam int unsigned HALF_W        = element_width * (NI / 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*HALF_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [HALF_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sel,
    output logic                out_last
);
    import complex_pkg::*;

    localparam int unsigned FULL_W = 2 * HALF_W;

    ser_state_e        state_q, state_d;
    logic [FULL_W-1:0] hold_q, hold_d;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State and holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next state; capture only happens on an accepted input
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (in_fire) begin
            hold_d = in_data;
        end
        case (state_q)
            IDLE:    if (in_fire)  state_d = LOW;
            LOW:     if (out_fire) state_d = HIGH;
            HIGH:    if (out_fire) state_d = in_fire ? LOW : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output mux; in IDLE the high half stays on out_data as the last beat sent
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sel   = 1'b0;
        out_last  = 1'b0;
        out_data  = hold_q[FULL_W-1:HALF_W];
        if (rst) begin
            out_data = '0;
        end else begin
            case (state_q)
                IDLE: in_ready = 1'b1;
                LOW: begin
                    out_valid = 1'b1;
                    out_data  = hold_q[HALF_W-1:0];
                end
                HIGH: begin
                    out_valid = 1'b1;
                    out_sel   = 1'b1;
                    out_last  = 1'b1;
                    in_ready  = out_ready;
                end
                default: in_ready = 1'b0;
            endcase
        end
    end

endmodule : complex_2n_to_n_serializer

// File: tb/tb_complex_2n_to_n_serializer.sv
// Self-checking bench: directed cycle table, back-to-back run, and randomized
// traffic against a beat-queue model with a demux round-trip check.
module tb_complex_2n_to_n_serializer;

    localparam int unsigned HW = 256;
    localparam int unsigned FW = 512;
    localparam int NROWS = 20;

    typedef struct {
        bit          r;
        bit          iv;
        logic [FW-1:0] din;
        bit          ordy;
        bit          e_ir;
        bit          e_ov;
        logic [HW-1:0] e_d;
        bit          e_sel;
        bit          e_last;
    } vec_t;

    typedef struct {
        logic [HW-1:0] d;
        bit            hi;
    } beat_t;

    logic          clk;
    logic          rst;
    logic [FW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;

    complex_2n_to_n_serializer_if #(.HALF_W(HW)) o_if ();

    complex_2n_to_n_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (o_if.data),
        .out_valid (o_if.valid),
        .out_ready (o_if.ready),
        .out_sel   (o_if.sel),
        .out_last  (o_if.last)
    );

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input bit r, input bit iv, input logic [FW-1:0] din, input bit ordy,
                                input bit eir, input bit eov, input logic [HW-1:0] ed,
                                input bit esel, input bit elast);
        vec_t v;
        v.r = r; v.iv = iv; v.din = din; v.ordy = ordy;
        v.e_ir = eir; v.e_ov = eov; v.e_d = ed; v.e_sel = esel; v.e_last = elast;
        return v;
    endfunction

    task automatic drive(input bit r, input bit iv, input logic [FW-1:0] din, input bit ordy);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_data   = din;
        o_if.ready = ordy;
        #1;
    endtask

    task automatic check(input string name, input bit eir, input bit eov, input logic [HW-1:0] ed,
                         input bit esel, input bit elast);
        logic [HW+3:0] act, exp;
        act = {in_ready, o_if.valid, o_if.sel, o_if.last, o_if.data};
        exp = {eir, eov, esel, elast, ed};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ir=%b ov=%b sel=%b last=%b data=%h, want ir=%b ov=%b sel=%b last=%b data=%h",
                     name, in_ready, o_if.valid, o_if.sel, o_if.last, o_if.data,
                     eir, eov, esel, elast, ed);
        end
    endtask

    vec_t          tbl [NROWS];
    logic [FW-1:0] v0, v1, v2, v3;
    logic [FW-1:0] bb [4];
    beat_t         q [$];
    logic [FW-1:0] sb [$];

    initial begin
        logic [HW-1:0] last_d, rt_low, ed;
        logic [FW-1:0] din, want;
        bit r, iv, ordy, eir, eov, esel;
        beat_t b;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; o_if.ready = 1'b1;

        v0 = {{32{8'hAA}}, {32{8'h11}}};
        v1 = {{32{8'h3E}}, {32{8'h5C}}};
        v2 = {{32{8'hC7}}, {32{8'h29}}};
        v3 = {{32{8'hF0}}, {32{8'h0F}}};

        // Directed cycle table: single vector, backpressure, ignored input, reset in HIGH
        tbl[0]  = mk(1, 0, '0, 1,  0, 0, '0,          0, 0);
        tbl[1]  = mk(0, 1, v0, 1,  1, 0, '0,          0, 0);
        tbl[2]  = mk(0, 0, '0, 1,  0, 1, v0[HW-1:0],  0, 0);
        tbl[3]  = mk(0, 0, '0, 1,  1, 1, v0[FW-1:HW], 1, 1);
        tbl[4]  = mk(0, 1, v1, 1,  1, 0, v0[FW-1:HW], 0, 0);
        tbl[5]  = mk(0, 1, v2, 0,  0, 1, v1[HW-1:0],  0, 0);
        tbl[6]  = mk(0, 1, v2, 0,  0, 1, v1[HW-1:0],  0, 0);
        tbl[7]  = mk(0, 1, v2, 0,  0, 1, v1[HW-1:0],  0, 0);
        tbl[8]  = mk(0, 0, '0, 1,  0, 1, v1[HW-1:0],  0, 0);
        tbl[9]  = mk(0, 1, v2, 0,  0, 1, v1[FW-1:HW], 1, 1);
        tbl[10] = mk(0, 1, v2, 0,  0, 1, v1[FW-1:HW], 1, 1);
        tbl[11] = mk(0, 1, v2, 0,  0, 1, v1[FW-1:HW], 1, 1);
        tbl[12] = mk(0, 1, v2, 1,  1, 1, v1[FW-1:HW], 1, 1);
        tbl[13] = mk(0, 0, '0, 1,  0, 1, v2[HW-1:0],  0, 0);
        tbl[14] = mk(0, 0, '0, 1,  1, 1, v2[FW-1:HW], 1, 1);
        tbl[15] = mk(0, 1, v3, 1,  1, 0, v2[FW-1:HW], 0, 0);
        tbl[16] = mk(0, 0, '0, 1,  0, 1, v3[HW-1:0],  0, 0);
        tbl[17] = mk(1, 0, '0, 1,  0, 0, '0,          0, 0);
        tbl[18] = mk(0, 0, '0, 1,  1, 0, '0,          0, 0);
        tbl[19] = mk(0, 0, '0, 1,  1, 0, '0,          0, 0);

        for (int i = 0; i < NROWS; i++) begin
            drive(tbl[i].r, tbl[i].iv, tbl[i].din, tbl[i].ordy);
            check($sformatf("table_row%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_d,
                  tbl[i].e_sel, tbl[i].e_last);
        end

        // Back-to-back: four vectors, in_valid held while the bench has data
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 16; w++) bb[k][w*32 +: 32] = $urandom();
        end
        for (int c = 0; c < 10; c++) begin
            iv  = (c % 2 == 0) && (c < 8);
            din = iv ? bb[c/2] : '0;
            drive(0, iv, din, 1);
            if (c == 0) begin
                check("b2b_idle", 1, 0, '0, 0, 0);
            end else if (c == 9) begin
                want = bb[3];
                check("b2b_end", 1, 0, want[FW-1:HW], 0, 0);
            end else if (c % 2 == 1) begin
                want = bb[(c-1)/2];
                check($sformatf("b2b_low%0d", (c-1)/2), 0, 1, want[HW-1:0], 0, 0);
            end else begin
                want = bb[c/2 - 1];
                check($sformatf("b2b_high%0d", c/2 - 1), 1, 1, want[FW-1:HW], 1, 1);
            end
        end

        // Randomized traffic against a queue-of-beats model plus demux reassembly
        last_d = '0;
        rt_low = '0;
        for (int i = 0; i < 1500; i++) begin
            r    = (i == 0) || ($urandom_range(0, 99) == 0);
            iv   = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            for (int w = 0; w < 16; w++) din[w*32 +: 32] = $urandom();
            drive(r, iv, din, ordy);

            if (r) begin
                check("rand_reset", 0, 0, '0, 0, 0);
                q.delete();
                sb.delete();
                last_d = '0;
            end else begin
                eov  = (q.size() > 0);
                ed   = eov ? q[0].d : last_d;
                esel = eov ? q[0].hi : 1'b0;
                eir  = (q.size() == 0) || (q.size() == 1 && ordy);
                check("rand_cycle", eir, eov, ed, esel, esel);

                if (eov && ordy) begin
                    b = q.pop_front();
                    last_d = b.d;
                    if (!o_if.sel) begin
                        rt_low = o_if.data;
                    end else if (sb.size() > 0) begin
                        want = sb.pop_front();
                        n_tests++;
                        if ({o_if.data, rt_low} !== want) begin
                            n_fail++;
                            $display("FAIL roundtrip: got %h, want %h", {o_if.data, rt_low}, want);
                        end
                    end
                end
                if (iv && eir) begin
                    q.push_back('{d: din[HW-1:0],  hi: 1'b0});
                    q.push_back('{d: din[FW-1:HW], hi: 1'b1});
                    sb.push_back(din);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_complex_2n_to_n_serializer
